// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// frame edge indices and the odd-parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_WAIT_IDLE
  } state_t;

  localparam int         FRAME_LEN   = 11;
  localparam logic [3:0] PARITY_EDGE = 4'd9;
  localparam logic [3:0] STOP_EDGE   = 4'd10;
  localparam logic [3:0] ACK_EDGE    = 4'(FRAME_LEN);

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-flop synchronizer for one PS/2 line plus a falling-edge strobe.
// Flops reset to 1 (idle line level) so reset release never fakes an edge.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  // Built from two registers, so the strobe is glitch-free.
  assign o_fall  = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame
// clocked by the device, ack sample, with an overall frame timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Fast_Clock,
  input  logic       Raw_Reset_I,
  input  logic [7:0] Tx_Byte,
  input  logic       Tx_Start,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_Ack_Err,
  output logic       Tx_Timeout,
  input  logic       KB_Clk_In,
  input  logic       KB_Data_In,
  output logic       KB_Clk_Drive_Low,
  output logic       KB_Data_Drive_Low,
  output logic       Rx_Inhibit
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t         r_state, w_state;
  logic [7:0]     r_byte, w_byte;
  logic           r_parity, w_parity;
  logic [3:0]     r_bitcnt, w_bitcnt;
  logic [TW-1:0]  r_tmr, w_tmr, w_tmr_inc;
  logic           r_clk_low, w_clk_low;
  logic           r_data_low, w_data_low;
  logic           r_busy, w_busy;
  logic           r_done, w_done;
  logic           r_ack_err, w_ack_err;
  logic           r_timeout, w_timeout;

  logic w_clk_lvl, w_clk_fall, w_data_lvl, w_data_fall_unused;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .gclk    (Fast_Clock),
    .grst_n  (Raw_Reset_I),
    .i_pin   (KB_Clk_In),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .gclk    (Fast_Clock),
    .grst_n  (Raw_Reset_I),
    .i_pin   (KB_Data_In),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall_unused)
  );

  assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + 1'b1;

  always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
    if (!Raw_Reset_I) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_bitcnt   <= '0;
      r_tmr      <= '0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_byte     <= w_byte;
      r_parity   <= w_parity;
      r_bitcnt   <= w_bitcnt;
      r_tmr      <= w_tmr;
      r_clk_low  <= w_clk_low;
      r_data_low <= w_data_low;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_ack_err  <= w_ack_err;
      r_timeout  <= w_timeout;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_byte     = r_byte;
    w_parity   = r_parity;
    w_bitcnt   = r_bitcnt;
    w_tmr      = r_tmr;
    w_clk_low  = r_clk_low;
    w_data_low = r_data_low;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_ack_err  = r_ack_err;
    w_timeout  = r_timeout;
    case (r_state)
      ST_IDLE: begin
        // Busy drops one cycle after Done, so a start in the Done cycle is refused.
        w_busy     = 1'b0;
        w_clk_low  = 1'b0;
        w_data_low = 1'b0;
        if (Tx_Start && !r_busy) begin
          w_state   = ST_INHIBIT;
          w_byte    = Tx_Byte;
          w_parity  = odd_parity(Tx_Byte);
          w_busy    = 1'b1;
          w_clk_low = 1'b1;
          w_ack_err = 1'b0;
          w_timeout = 1'b0;
          w_tmr     = '0;
        end
      end
      ST_INHIBIT: begin
        if (r_tmr == INH_LAST) begin
          w_data_low = 1'b1;
          w_state    = ST_RTS;
        end else begin
          w_tmr = w_tmr_inc;
        end
      end
      ST_RTS: begin
        w_clk_low = 1'b0;
        w_tmr     = '0;
        w_bitcnt  = '0;
        w_state   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_tmr == TMO_LAST) begin
          w_clk_low  = 1'b0;
          w_data_low = 1'b0;
          w_timeout  = 1'b1;
          w_ack_err  = 1'b0;
          w_done     = 1'b1;
          w_state    = ST_IDLE;
        end else begin
          w_tmr = w_tmr_inc;
          if (w_clk_fall) begin
            w_bitcnt = r_bitcnt + 4'd1;
            if (w_bitcnt <= 4'd8) begin
              w_data_low = ~r_byte[r_bitcnt[2:0]];
            end else if (w_bitcnt == PARITY_EDGE) begin
              w_data_low = ~r_parity;
            end else if (w_bitcnt == STOP_EDGE) begin
              w_data_low = 1'b0;
            end else if (w_bitcnt == ACK_EDGE) begin
              w_data_low = 1'b0;
              w_ack_err  = w_data_lvl;
              w_state    = ST_WAIT_IDLE;
            end
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_lvl && w_data_lvl) begin
          w_done  = 1'b1;
          w_state = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign Tx_Busy           = r_busy;
  assign Tx_Done           = r_done;
  assign Tx_Ack_Err        = r_ack_err;
  assign Tx_Timeout        = r_timeout;
  assign KB_Clk_Drive_Low  = r_clk_low;
  assign KB_Data_Drive_Low = r_data_low;
  assign Rx_Inhibit        = r_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a PS/2 device that
// clocks frames, decodes the data line and acks or naks.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;
  localparam int H   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, ack_err, tmo_o, clk_drv, data_drv, rx_inh;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       kb_clk, kb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign kb_clk  = ~(clk_drv | dev_clk_low);
  assign kb_data = ~(data_drv | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .Fast_Clock        (clk),
    .Raw_Reset_I       (rst_n),
    .Tx_Byte           (tx_byte),
    .Tx_Start          (tx_start),
    .Tx_Busy           (busy),
    .Tx_Done           (done),
    .Tx_Ack_Err        (ack_err),
    .Tx_Timeout        (tmo_o),
    .KB_Clk_In         (kb_clk),
    .KB_Data_In        (kb_data),
    .KB_Clk_Drive_Low  (clk_drv),
    .KB_Data_Drive_Low (data_drv),
    .Rx_Inhibit        (rx_inh)
  );

  // Frame as seen on the wire: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    tx_byte  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device: waits for request-to-send, then clocks n_edges falling edges.
  // With n_edges < 11 it returns holding the clock low.
  task automatic dev_frame(input bit ack, input int n_edges, output logic [10:0] bits, output bit ok);
    int t;
    t = 0; bits = '1; ok = 1'b0;
    while (!(kb_clk && !kb_data) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) return;
    bits[0] = kb_data;
    cyc(5);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk_low = 1'b1;
      cyc(H);
      if (e == n_edges && n_edges < 11) begin
        ok = 1'b1;
        return;
      end
      dev_clk_low = 1'b0;
      if (e <= 10) bits[e] = kb_data;
      if (e == 10 && ack) dev_data_low = 1'b1;
      cyc(H);
    end
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_done(input string tag, output bit seen, output logic ae, output logic to);
    int t;
    t = 0; seen = 1'b0; ae = 1'b0; to = 1'b0;
    while (t < 3000) begin
      if (done) begin
        seen = 1'b1; ae = ack_err; to = tmo_o;
        break;
      end
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) chk({tag, "_lines_released"}, {30'd0, clk_drv, data_drv}, 32'd0);
  endtask

  task automatic measure_inh(output int n_inh, output int n_rts);
    int t;
    t = 0; n_inh = 0; n_rts = 0;
    while (t < 500) begin
      if (clk_drv && !data_drv) n_inh++;
      else if (clk_drv && data_drv) n_rts++;
      else if (n_inh > 0) break;
      @(negedge clk);
      t++;
    end
  endtask

  // Per-cycle protocol invariants.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rx_inhibit_eq_busy", 32'(rx_inh), 32'(busy));
      if (!busy) chk("idle_quiet", {29'd0, clk_drv, data_drv, done}, 32'd0);
      if (prev_done) chk("busy_drops_after_done", 32'(busy), 32'd0);
      if (done) chk("done_while_busy", 32'(busy), 32'd1);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  logic [7:0]  pb [3] = '{8'h00, 8'hFF, 8'h01};
  logic [10:0] pl [3] = '{11'h600, 11'h7FE, 11'h402};

  initial begin
    logic [10:0] bits;
    bit          ok, seen, any;
    logic        ae, to;
    int          ni, nr, n;

    cyc(3);
    chk("reset_outputs", {25'd0, busy, done, ack_err, tmo_o, clk_drv, data_drv, rx_inh}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // 0xED with ack, inhibit/RTS timing measured in parallel
    start_tx(8'hED);
    fork
      dev_frame(1'b1, 11, bits, ok);
      wait_done("ed", seen, ae, to);
      measure_inh(ni, nr);
    join
    chk("ed_dev_ok", 32'(ok), 32'd1);
    chk("ed_frame_model", 32'(bits), 32'(model_frame(8'hED)));
    chk("ed_frame_literal", 32'(bits), 32'h7DA);
    chk("ed_ack_err", 32'(ae), 32'd0);
    chk("ed_timeout", 32'(to), 32'd0);
    chk("inhibit_len", ni, INH);
    chk("rts_len", nr, 1);
    cyc(3);

    // parity corners
    for (int i = 0; i < 3; i++) begin
      start_tx(pb[i]);
      fork
        dev_frame(1'b1, 11, bits, ok);
        wait_done("parity", seen, ae, to);
      join
      chk("parity_frame_model", 32'(bits), 32'(model_frame(pb[i])));
      chk("parity_frame_literal", 32'(bits), 32'(pl[i]));
      chk("parity_ack_err", 32'(ae), 32'd0);
      cyc(3);
    end

    // device never acks
    start_tx(8'h55);
    fork
      dev_frame(1'b0, 11, bits, ok);
      wait_done("nack", seen, ae, to);
    join
    chk("nack_frame_model", 32'(bits), 32'(model_frame(8'h55)));
    chk("nack_ack_err", 32'(ae), 32'd1);
    chk("nack_timeout", 32'(to), 32'd0);
    cyc(10);
    chk("ack_err_hold", 32'(ack_err), 32'd1);

    // timeout: device never clocks
    start_tx(8'h42);
    chk("ack_err_cleared_on_start", 32'(ack_err), 32'd0);
    n = 0;
    while (!(!clk_drv && data_drv) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!done && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_len", n, TMO);
    wait_done("tmo", seen, ae, to);
    chk("tmo_flag", 32'(to), 32'd1);
    chk("tmo_ack_err", 32'(ae), 32'd0);
    cyc(5);
    chk("timeout_hold", 32'(tmo_o), 32'd1);

    // start while busy is ignored
    start_tx(8'h5A);
    fork
      dev_frame(1'b1, 11, bits, ok);
      wait_done("busy_ign", seen, ae, to);
      begin
        cyc(100);
        start_tx(8'h3C);
      end
    join
    chk("busy_ign_frame", 32'(bits), 32'(model_frame(8'h5A)));
    chk("busy_ign_timeout_cleared", 32'(to), 32'd0);
    any = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy) any = 1'b1;
    end
    chk("no_restart", 32'(any), 32'd0);

    // reset mid-frame after edge 5 (bit4 of 0xA5 is 0, so data is pulled low)
    start_tx(8'hA5);
    dev_frame(1'b1, 5, bits, ok);
    chk("pre_reset_dev_ok", 32'(ok), 32'd1);
    chk("pre_reset_data_drive", 32'(data_drv), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_drives", {30'd0, clk_drv, data_drv}, 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    chk("reset_mid_done", 32'(done), 32'd0);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    any = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) any = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) any = 1'b1;
    end
    chk("no_done_after_reset", 32'(any), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on the same KB_Clk/KB_Data pins that the PS2 receiver block listens on. It drives both lines open-drain as "pull low" enables and sequences the inhibit / request-to-send / 11-bit frame / acknowledge protocol. It sits beside PS2 and is driven by IO_Module, so software can write to the keyboard.

Parameters:
INHIBIT_CYCLES, 6000, Fast_Clock cycles that KB_Clk is held low before request-to-send (120 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum Fast_Clock cycles from clock release to ack sample before the frame is aborted (20 ms).
SYNC_STAGES, 2, synchronizer flops on KB_Clk_In and KB_Data_In (minimum 2).

Ports:
Fast_Clock  in  1  system clock; the only clock.
Raw_Reset_I  in  1  asynchronous, active-low reset.
Tx_Byte  in  8  byte to send; sampled on the accepted Tx_Start cycle.
Tx_Start  in  1  one-cycle request; ignored unless Tx_Busy=0.
Tx_Busy  out  1  high from the accepted start until the cycle after Tx_Done.
Tx_Done  out  1  one-cycle completion pulse (success or failure).
Tx_Ack_Err  out  1  valid with Tx_Done: device did not acknowledge.
Tx_Timeout  out  1  valid with Tx_Done: frame aborted by timeout.
KB_Clk_In  in  1  raw PS/2 clock pin level.
KB_Data_In  in  1  raw PS/2 data pin level.
KB_Clk_Drive_Low  out  1  1 = pull KB_Clk low; 0 = release.
KB_Data_Drive_Low  out  1  1 = pull KB_Data low; 0 = release.
Rx_Inhibit  out  1  equals Tx_Busy; the receiver discards bits while high.

Behaviour:
- Reset (async, Raw_Reset_I=0): state IDLE. All outputs 0, both lines released, all counters cleared. Reset mid-frame releases both lines immediately; no Tx_Done is issued.
- Inputs pass through SYNC_STAGES flops. A falling edge of KB_Clk is registered in the cycle after the synchronized level goes from 1 to 0, i.e. SYNC_STAGES+1 cycles after the pin edge.
- Frame bits are data LSB first, then odd parity (parity = ~^Tx_Byte), then stop bit (line released = 1).
- IDLE: Tx_Start=1 latches Tx_Byte and computes parity → INHIBIT. KB_Clk_Drive_Low=1 in the following cycle.
- INHIBIT: count INHIBIT_CYCLES. On the last count, set KB_Data_Drive_Low=1 (start bit) → RTS.
- RTS: one cycle later release KB_Clk. Clear the timeout counter → SHIFT.
- SHIFT: falling edges are numbered n=1..11.
  - n=1..8: drive data bit n-1 (KB_Data_Drive_Low = ~bit).
  - n=9: drive parity.
  - n=10: release data (stop bit).
  - n=11: sample the synchronized KB_Data; 0 = ack OK, 1 = Tx_Ack_Err → WAIT_IDLE.
  - Line updates happen in the cycle the edge is registered.
- WAIT_IDLE: wait until synchronized KB_Clk=1 and KB_Data=1 for one cycle. Then pulse Tx_Done → IDLE.
- Timeout: counter runs from RTS through SHIFT. When it reaches TIMEOUT_CYCLES, release both lines, pulse Tx_Done with Tx_Timeout=1 and Tx_Ack_Err=0 → IDLE. Timeout takes precedence over a falling edge in the same cycle.
- Tx_Ack_Err and Tx_Timeout hold their values until the next accepted Tx_Start, which clears both.
- Tx_Start while busy: ignored; latched byte unchanged.
- Glitches on KB_Clk while in INHIBIT or RTS: ignored; the edge counter is enabled only in SHIFT.
- Widths: bit counter 4 bits; timers $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1) bits, saturating without wrap.

Decomposition:
- Shared package: state encoding (IDLE, INHIBIT, RTS, SHIFT, WAIT_IDLE), frame length constant 11, ack edge index 11, stop edge index 10.
- One natural sub-module: ps2_line_sync (SYNC_STAGES synchronizer plus falling-edge pulse). It is also reusable by the receiver.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz → data-line bits seen at rising edges are 0,1,0,1,1,0,1,1,1,1(parity),1(stop). Device acks at edge 11 → Tx_Done=1, Tx_Ack_Err=0, Tx_Timeout=0.
- Parity corners: 0x00 → parity 1; 0xFF → parity 1; 0x01 → parity 0. Each is checked by the model's frame decode.
- INHIBIT_CYCLES=20: KB_Clk_Drive_Low high for exactly 20 cycles before KB_Data_Drive_Low rises. Clock released one cycle later.
- Model leaves data high at edge 11 → Tx_Done with Tx_Ack_Err=1, both lines released.
- TIMEOUT_CYCLES=500, model never clocks → Tx_Done with Tx_Timeout=1 exactly 500 cycles after clock release, lines released.
- Tx_Start during SHIFT with a different byte → ignored, original byte completes. Assert Raw_Reset_I=0 after edge 5 → both drives 0 in the same cycle, Tx_Busy=0, no Tx_Done.
